// File: rtl/cache_flush_ctrl.sv
// cache_flush_ctrl
// Walks every (set, way) of a set-associative cache after a flush command.
// Each dirty line is written back over a req/ack handshake, and its dirty
// bit is then cleared. While the walk runs, FlushStall hands ownership of
// the tag/data arrays to this block.
//
// Build option: define FLUSH_SKIP_CLEAN_EN to skip the remaining ways of a
// set once no dirty bit is left at or above the current way. Writeback and
// dirty-clear behaviour are the same with or without it.
module cache_flush_ctrl #(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushCache,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic               WbAck,
    output logic [SETLEN-1:0]  FlushAdr,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               WbReq,
    output logic               ClearDirty,
    output logic               FlushStall,
    output logic               FlushDone
);

    localparam int                WAYLEN   = $clog2(NUMWAYS);
    localparam logic [WAYLEN-1:0] LAST_WAY = WAYLEN'(NUMWAYS - 1);
    localparam logic [SETLEN-1:0] LAST_SET = SETLEN'(NUMLINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        WB,
        CLEAR,
        NEXT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SETLEN-1:0] set_cnt;
    logic [SETLEN-1:0] set_cnt_next;
    logic [WAYLEN-1:0] way_cnt;
    logic [WAYLEN-1:0] way_cnt_next;
    logic              way_dirty;

`ifdef FLUSH_SKIP_CLEAN_EN
    logic              upper_dirty;
`endif

    // Dirty bit of the way under inspection, plus (with skipping enabled)
    // whether any dirty bit remains at this way index or above it.
    always_comb begin
        way_dirty = DirtyWay[way_cnt];
`ifdef FLUSH_SKIP_CLEAN_EN
        upper_dirty = ((DirtyWay >> way_cnt) != '0);
`endif
    end

    // State and the set/way counters. Reset abandons any walk in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            set_cnt <= '0;
            way_cnt <= '0;
        end else begin
            state   <= state_next;
            set_cnt <= set_cnt_next;
            way_cnt <= way_cnt_next;
        end
    end

    // Next state, counter updates and the strobes decoded from the state.
    always_comb begin
        state_next   = state;
        set_cnt_next = set_cnt;
        way_cnt_next = way_cnt;
        WbReq        = 1'b0;
        ClearDirty   = 1'b0;
        FlushDone    = 1'b0;

        case (state)
            IDLE: begin
                if (FlushCache) begin
                    state_next = READ;
                end
            end

            READ: begin
                state_next = CHECK;
            end

            CHECK: begin
                if (way_dirty) begin
                    state_next = WB;
`ifdef FLUSH_SKIP_CLEAN_EN
                end else if (!upper_dirty) begin
                    way_cnt_next = LAST_WAY;
                    state_next   = NEXT;
`endif
                end else begin
                    state_next = NEXT;
                end
            end

            WB: begin
                WbReq = 1'b1;
                if (WbAck) begin
                    state_next = CLEAR;
                end
            end

            CLEAR: begin
                ClearDirty = 1'b1;
                state_next = NEXT;
            end

            NEXT: begin
                if (way_cnt != LAST_WAY) begin
                    way_cnt_next = way_cnt + WAYLEN'(1);
                    state_next   = CHECK;
                end else if (set_cnt != LAST_SET) begin
                    way_cnt_next = '0;
                    set_cnt_next = set_cnt + SETLEN'(1);
                    state_next   = READ;
                end else begin
                    state_next = DONE;
                end
            end

            DONE: begin
                FlushDone    = 1'b1;
                set_cnt_next = '0;
                way_cnt_next = '0;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Array-side address outputs. These come straight from the registers,
    // so an asynchronous reset clears them at once.
    always_comb begin
        FlushAdr   = set_cnt;
        FlushWay   = '0;
        FlushStall = (state != IDLE);
        if (state != IDLE) begin
            FlushWay[way_cnt] = 1'b1;
        end
    end

endmodule
